// File: rtl/main_mem_ctrl.sv
// rtl/main_mem_ctrl.sv - fixed-latency block memory serving cache refills and writebacks
// Optional preload of the array at time zero: define MAIN_MEM_INIT_EN.
module main_mem_ctrl #(
    parameter int PA_WIDTH   = 32,
    parameter int MEM_WIDTH  = 512,
    parameter int BO_WIDTH   = 6,
    parameter int DEPTH_LOG2 = 10,
    parameter int LAT        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PA_WIDTH-1:0]  mem_addr,
    input  logic                 mem_rd_en,
    input  logic                 mem_wr_en,
    input  logic [MEM_WIDTH-1:0] mem_wr_blk,
    output logic [MEM_WIDTH-1:0] mem_rd_blk,
    output logic                 mem_ready,
    output logic                 mem_busy,
    output logic                 mem_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    typedef logic [MEM_WIDTH-1:0] mem_t [DEPTH];

`ifdef MAIN_MEM_INIT_EN
    function automatic mem_t preload();
        mem_t m;
        for (int b = 0; b < DEPTH; b++) begin
            for (int w = 0; w < MEM_WIDTH / 32; w++) begin
                m[b][32*w +: 32] = {b[15:0], w[15:0]};
            end
        end
        return m;
    endfunction

    mem_t mem = preload();
`else
    mem_t mem;
`endif

    state_t                 state, state_next;
    logic [3:0]             cnt;
    logic [DEPTH_LOG2-1:0]  idx;
    logic [MEM_WIDTH-1:0]   wr_q;
    logic                   err_q;
    logic                   commit;
    logic                   unused_addr_bits;

    // Only the index field selects a block; offset and upper bits alias.
    assign unused_addr_bits = ^mem_addr;
    assign commit = (state == READ || state == WRITE) && cnt == 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_rd_en && !mem_wr_en)      state_next = READ;
                else if (mem_wr_en && !mem_rd_en) state_next = WRITE;
            end
            READ, WRITE: if (cnt == 4'd0) state_next = DONE;
            DONE:        state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state == DONE);
        mem_busy  = (state != IDLE);
        mem_err   = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            wr_q       <= '0;
            err_q      <= 1'b0;
            mem_rd_blk <= '0;
        end else begin
            err_q <= (state == IDLE) && mem_rd_en && mem_wr_en;
            if (state == IDLE && (mem_rd_en ^ mem_wr_en)) begin
                cnt  <= LAT_M1;
                idx  <= mem_addr[BO_WIDTH +: DEPTH_LOG2];
                wr_q <= mem_wr_blk;
            end else if ((state == READ || state == WRITE) && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && state == READ) mem_rd_blk <= mem[idx];
        end
    end

    // Array has no reset: contents survive rst, and an aborted write never reaches commit.
    always_ff @(posedge clk) begin
        if (commit && state == WRITE) mem[idx] <= wr_q;
    end
endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb/tb_main_mem_ctrl.sv - directed self-checking bench for main_mem_ctrl
module tb_main_mem_ctrl;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_addr;
    logic         mem_rd_en;
    logic         mem_wr_en;
    logic [511:0] mem_wr_blk;
    logic [511:0] mem_rd_blk;
    logic         mem_ready;
    logic         mem_busy;
    logic         mem_err;

    int checks = 0;
    int errors = 0;

    main_mem_ctrl #(
        .PA_WIDTH(32), .MEM_WIDTH(512), .BO_WIDTH(6), .DEPTH_LOG2(10), .LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_wr_blk(mem_wr_blk), .mem_rd_blk(mem_rd_blk),
        .mem_ready(mem_ready), .mem_busy(mem_busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pat(input logic [15:0] b);
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[32*w +: 32] = {b, 16'(w)};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request held until mem_ready, with inputs scrambled after accept.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [511:0] blk, input string tag);
        int n;
        mem_addr = addr; mem_rd_en = rd; mem_wr_en = wr; mem_wr_blk = blk;
        tick();
        check({tag, "_busy"}, 512'(mem_busy), 512'(1));
        mem_wr_blk = ~blk;
        mem_addr   = addr ^ 32'h40;
        n = 0;
        while (!mem_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 512'(n), 512'(LAT));
        mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        tick();
        check({tag, "_idle"}, 512'({mem_busy, mem_ready}), 512'(0));
    endtask

    initial begin
        rst = 1'b1; mem_addr = '0; mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_wr_blk = '0;
        #2;
        check("reset_outputs", 512'({mem_ready, mem_busy, mem_err}), 512'(0));
        check("reset_rd_blk", mem_rd_blk, 512'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_access(1'b0, 1'b1, 32'h0000_0100, {64{8'hA5}}, "wr_a5");
        check("write_leaves_rd_blk", mem_rd_blk, 512'(0));
        do_access(1'b1, 1'b0, 32'h0000_013C, '0, "rd_a5");
        check("read_a5", mem_rd_blk, {64{8'hA5}});

        mem_addr = 32'h0000_0100; mem_wr_blk = '0; mem_rd_en = 1'b1; mem_wr_en = 1'b1;
        tick();
        check("both_err", 512'(mem_err), 512'(1));
        check("both_not_busy", 512'(mem_busy), 512'(0));
        mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        tick();
        check("err_one_cycle", 512'(mem_err), 512'(0));
        do_access(1'b1, 1'b0, 32'h0000_0100, '0, "rd_after_err");
        check("array_unchanged", mem_rd_blk, {64{8'hA5}});

        do_access(1'b0, 1'b1, 32'h0000_0080, pat(16'd2), "wr_b2");
        mem_addr = 32'h0000_0080; mem_wr_blk = '1; mem_wr_en = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_outputs", 512'({mem_ready, mem_busy, mem_err}), 512'(0));
        check("midrst_rd_blk", mem_rd_blk, 512'(0));
        mem_wr_en = 1'b0;
        tick();
        rst = 1'b0;
        do_access(1'b1, 1'b0, 32'h0000_0080, '0, "rd_b2");
        check("abort_word0", 512'(mem_rd_blk[31:0]), 512'(32'h0002_0000));
        check("abort_word15", 512'(mem_rd_blk[511:480]), 512'(32'h0002_000F));

        do_access(1'b0, 1'b1, 32'h0000_0000, pat(16'd0), "wr_b0");
        check("rd_blk_held", mem_rd_blk, pat(16'd2));
        do_access(1'b1, 1'b0, 32'h0001_0000, '0, "rd_alias");
        check("alias_block", mem_rd_blk, pat(16'd0));

        // Enables held through DONE start a second request once IDLE is re-entered.
        mem_addr = 32'h0000_0080; mem_rd_en = 1'b1;
        repeat (LAT + 1) tick();
        check("held_done", 512'(mem_ready), 512'(1));
        tick();
        check("held_idle", 512'(mem_busy), 512'(0));
        tick();
        check("held_restart", 512'(mem_busy), 512'(1));
        mem_rd_en = 1'b0;
        repeat (LAT + 2) tick();
        check("held_end_idle", 512'(mem_busy), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
